// File: rtl/tow_pb_cond_pkg.sv
// Shared definitions for the tug-of-war push-button conditioning stage.
package tow_pb_cond_pkg;

  // Debounce lengths: short for simulation, ~20 ms at 50 MHz for board builds.
  localparam int unsigned TOW_DEB_CYCLES_SIM = 4;
  localparam int unsigned TOW_DEB_CYCLES_HW  = 1_000_000;

  // Conditioned view of one button.
  typedef struct packed {
    logic pulse;
    logic held;
  } pb_out_t;

  // Debounce counter width: $clog2(n), never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tow_pb_chan.sv
// One push-button channel: synchronizer, debounce counter, press-edge pulse.
module tow_pb_chan
  import tow_pb_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = TOW_DEB_CYCLES_SIM
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    raw,
  output pb_out_t out
);

  localparam int unsigned      CNT_W   = cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic                   deb;
  logic                   pulse;

  assign s = sync[SYNC_STAGES-1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it has been stable for DEB_CYCLES edges;
  // any return to the current level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      deb   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (s == deb) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        deb   <= s;
        cnt   <= '0;
        pulse <= s;  // strobe only on the press direction
      end
    end
  end

  assign out.pulse = pulse;
  assign out.held  = deb;

endmodule

// File: rtl/tow_pb_cond.sv
// Conditions the left/right buttons into single press pulses and held levels.
module tow_pb_cond
  import tow_pb_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEB_CYCLES  = TOW_DEB_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  output logic l_pulse,
  output logic r_pulse,
  output logic l_held,
  output logic r_held
);

  pb_out_t l_out;
  pb_out_t r_out;

  tow_pb_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_left (
    .clk(clk),
    .rst(rst),
    .raw(pbl),
    .out(l_out)
  );

  tow_pb_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_right (
    .clk(clk),
    .rst(rst),
    .raw(pbr),
    .out(r_out)
  );

  assign l_pulse = l_out.pulse;
  assign l_held  = l_out.held;
  assign r_pulse = r_out.pulse;
  assign r_held  = r_out.held;

endmodule
